// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM state encoding and reset PC.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pc_state_t;

   localparam int RESET_PC = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clr wins over inc, holds at all-ones.
// Latency: count reflects clr/inc one cycle after the sampling edge; no backpressure.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller owning the instruction-memory PC: start, stall, jump, branch, halt.
// Latency: next PC visible one cycle after the decode inputs; stall freezes PC, count and state.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_BITS  = 12,
   parameter int OFF_BITS = 8,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [PC_BITS-1:0]  start_addr,
   input  logic                stall,
   input  logic                jump,
   input  logic [PC_BITS-1:0]  jump_target,
   input  logic                branch,
   input  logic [OFF_BITS-1:0] branch_off,
   input  logic                halt,
   output logic [PC_BITS-1:0]  pc,
   output logic                fetch_valid,
   output logic                busy,
   output logic                done,
   output logic [CNT_BITS-1:0] retired
);

   pc_state_t          state_q, state_d;
   logic [PC_BITS-1:0] pc_q, pc_d;
   logic [PC_BITS-1:0] off_ext;
   logic               cnt_clr, cnt_inc;

   assign off_ext = {{(PC_BITS-OFF_BITS){branch_off[OFF_BITS-1]}}, branch_off};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         RUN: begin
            if (!stall) begin
               cnt_inc = 1'b1;
               if (halt) begin
                  state_d = DONE;
               end else if (jump) begin
                  pc_d = jump_target;
               end else if (branch) begin
                  pc_d = pc_q + off_ext;
               end else begin
                  pc_d = pc_q + PC_BITS'(1);
               end
            end
         end
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = start_addr;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = PC_BITS'(RESET_PC);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= PC_BITS'(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   sat_counter #(
      .WIDTH(CNT_BITS)
   ) u_retired (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (retired)
   );

   assign pc   = pc_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   // The one path from an input: a stalled cycle must not present a live fetch.
   assign fetch_valid = busy & ~stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model plus directed literal checks.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] start_addr = '0;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic [11:0] jump_target = '0;
   logic        branch = 1'b0;
   logic [7:0]  branch_off = '0;
   logic        halt = 1'b0;

   logic [11:0] pc, pc4;
   logic        fetch_valid, busy, done;
   logic        fetch_valid4, busy4, done4;
   logic [15:0] retired;
   logic [3:0]  retired4;

   int tests = 0;
   int fails = 0;

   pc_sequencer #(.PC_BITS(12), .OFF_BITS(8), .CNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .stall(stall), .jump(jump), .jump_target(jump_target),
      .branch(branch), .branch_off(branch_off), .halt(halt),
      .pc(pc), .fetch_valid(fetch_valid), .busy(busy), .done(done),
      .retired(retired)
   );

   pc_sequencer #(.PC_BITS(12), .OFF_BITS(8), .CNT_BITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .stall(stall), .jump(jump), .jump_target(jump_target),
      .branch(branch), .branch_off(branch_off), .halt(halt),
      .pc(pc4), .fetch_valid(fetch_valid4), .busy(busy4), .done(done4),
      .retired(retired4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 = idle, 1 = running, 2 = finished; pc and count as plain integers.
   int m_mode = 0;
   int m_pc   = 0;
   int m_cnt  = 0;

   always @(posedge clk or posedge reset) begin
      int off;
      if (reset) begin
         m_mode = 0;
         m_pc   = 0;
         m_cnt  = 0;
      end else if (m_mode == 1) begin
         if (!stall) begin
            m_cnt = m_cnt + 1;
            off = branch_off[7] ? int'(branch_off) - 256 : int'(branch_off);
            if (halt)        m_mode = 2;
            else if (jump)   m_pc = int'(jump_target);
            else if (branch) m_pc = (m_pc + off + 4096) % 4096;
            else             m_pc = (m_pc + 1) % 4096;
         end
      end else if (start) begin
         m_mode = 1;
         m_pc   = int'(start_addr);
         m_cnt  = 0;
      end
   end

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   always @(negedge clk) begin
      chk("pc", int'(pc), m_pc);
      chk("busy", int'(busy), int'(m_mode == 1));
      chk("done", int'(done), int'(m_mode == 2));
      chk("fetch_valid", int'(fetch_valid), int'((m_mode == 1) && !stall));
      chk("retired", int'(retired), sat(m_cnt, 65535));
      chk("retired_w4", int'(retired4), sat(m_cnt, 15));
      chk("pc_w4", int'(pc4), m_pc);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #1 reset = 1'b1;
      cyc(2);
      chk("rst_pc", int'(pc), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fv", int'(fetch_valid), 0);
      chk("rst_retired", int'(retired), 0);
      reset = 1'b0;
      cyc(1);

      // Start at 0x010 and free-run four instructions.
      start = 1'b1; start_addr = 12'h010;
      cyc(1);
      start = 1'b0;
      chk("start_pc", int'(pc), 12'h010);
      chk("start_busy", int'(busy), 1);
      chk("start_fv", int'(fetch_valid), 1);
      cyc(1);
      chk("seq_pc1", int'(pc), 12'h011);
      cyc(3);
      chk("seq_pc4", int'(pc), 12'h014);
      chk("seq_retired", int'(retired), 4);

      // Backward branch, then jump beating branch.
      jump = 1'b1; jump_target = 12'h020;
      cyc(1);
      jump = 1'b0;
      chk("jump_pc", int'(pc), 12'h020);
      branch = 1'b1; branch_off = 8'hFC;
      cyc(1);
      chk("branch_back", int'(pc), 12'h01C);
      jump = 1'b1; jump_target = 12'h100;
      cyc(1);
      jump = 1'b0; branch = 1'b0;
      chk("jump_wins", int'(pc), 12'h100);

      // PC wrap and large negative branch wrap.
      jump = 1'b1; jump_target = 12'hFFF;
      cyc(1);
      jump = 1'b0;
      cyc(1);
      chk("inc_wrap", int'(pc), 12'h000);
      jump = 1'b1; jump_target = 12'h002;
      cyc(1);
      jump = 1'b0; branch = 1'b1; branch_off = 8'h80;
      cyc(1);
      branch = 1'b0;
      chk("branch_wrap", int'(pc), 12'hF82);
      chk("retired_11", int'(retired), 11);

      // Stall masks a pending halt.
      stall = 1'b1; halt = 1'b1;
      cyc(3);
      chk("stall_pc", int'(pc), 12'hF82);
      chk("stall_retired", int'(retired), 11);
      chk("stall_busy", int'(busy), 1);
      chk("stall_fv", int'(fetch_valid), 0);
      stall = 1'b0;
      cyc(1);
      halt = 1'b0;
      chk("halt_done", int'(done), 1);
      chk("halt_busy", int'(busy), 0);
      chk("halt_retired", int'(retired), 12);
      chk("halt_pc", int'(pc), 12'hF82);

      // Controls ignored in DONE, then restart.
      jump = 1'b1; jump_target = 12'h777;
      cyc(1);
      jump = 1'b0;
      chk("done_hold_pc", int'(pc), 12'hF82);
      start = 1'b1; start_addr = 12'h005;
      cyc(1);
      start = 1'b0;
      chk("restart_pc", int'(pc), 12'h005);
      chk("restart_retired", int'(retired), 0);
      chk("restart_done", int'(done), 0);
      chk("restart_busy", int'(busy), 1);

      // Twenty instructions; a stray start in RUN is ignored.
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         start_addr = 12'h300;
         cyc(1);
         if (i == 14) chk("sat_reach", int'(retired4), 15);
      end
      start = 1'b0;
      chk("run20_pc", int'(pc), 12'h019);
      chk("run20_retired", int'(retired), 20);
      chk("run20_sat", int'(retired4), 15);

      // Asynchronous reset mid-RUN.
      reset = 1'b1;
      #1;
      chk("arst_pc", int'(pc), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_retired", int'(retired), 0);
      chk("arst_fv", int'(fetch_valid), 0);
      chk("arst_done", int'(done), 0);
      cyc(1);
      reset = 1'b0;
      cyc(2);
      chk("post_rst_idle_pc", int'(pc), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
